project3a_top: RTL and testbench

//  Top level for the switch-to-display lab board. Samples a 6-bit operand on SW[5:0].

---
 rtl/project3a_top_if.sv | 14 +
 rtl/project3a_top.sv | 122 ++++++++++++
 tb/tb_project3a_top.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/project3a_top_if.sv
// Board-side bundle for project3a_top: switch inputs, status LEDs and six 7-segment digits.
interface project3a_top_if;
  logic [9:0] SW;
  logic [9:0] LED;
  logic [6:0] HEX0;
  logic [6:0] HEX1;
  logic [6:0] HEX2;
  logic [6:0] HEX3;
  logic [6:0] HEX4;
  logic [6:0] HEX5;

  modport master (output SW, input LED, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5);
  modport slave  (input SW, output LED, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5);
endinterface

// File: rtl/project3a_top.sv
// Switch-to-display top: 6-bit operand shown in decimal (signed/unsigned) on 7-segment digits.
// Optional feature macro: HEX_MODE_EN (SW[7]=1 selects hexadecimal display).
module project3a_top #(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  project3a_top_if.slave  board
);

  localparam logic [6:0] BLANK = 7'h7F;

  // Double-dabble over 6 bits: {tens, ones}; magnitude never exceeds 63.
  function automatic logic [7:0] bin2bcd(input logic [5:0] bin);
    logic [7:0] bcd;
    bcd = 8'd0;
    for (int i = 5; i >= 0; i--) begin
      if (bcd[3:0] >= 4'd5) bcd[3:0] = bcd[3:0] + 4'd3;
      else                  bcd[3:0] = bcd[3:0];
      if (bcd[7:4] >= 4'd5) bcd[7:4] = bcd[7:4] + 4'd3;
      else                  bcd[7:4] = bcd[7:4];
      bcd = {bcd[6:0], bin[i]};
    end
    return bcd;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h10;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h46;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      4'hF:    g = 7'h0E;
      default: g = BLANK;
    endcase
    return g;
  endfunction

  logic [9:0] sw_q_r;
  logic [9:0] led_r;
  logic [6:0] hex0_r, hex1_r, hex2_r, hex3_r, hex4_r, hex5_r;

  logic       neg_s;
  logic [5:0] mag_s;
  logic [7:0] bcd_s;
  logic [9:0] led_s;
  logic [6:0] hex0_s, hex1_s, hex3_s, hex4_s;
  logic       unused_s;

  // SW[9:8] are spare switches; SW[7] only matters in hex-mode builds.
  assign unused_s = ^sw_q_r[9:7];

  // Convert the sampled operand into LED status and segment patterns.
  always_comb begin
    neg_s = sw_q_r[6] & sw_q_r[5];
    if (neg_s) mag_s = 6'd0 - sw_q_r[5:0];
    else       mag_s = sw_q_r[5:0];
    bcd_s  = bin2bcd(mag_s);
    hex0_s = glyph(bcd_s[3:0]);
    if (bcd_s[7:4] != 4'd0) hex1_s = glyph(bcd_s[7:4]);
    else                    hex1_s = BLANK;
    if (sw_q_r[6]) hex4_s = 7'h12;
    else           hex4_s = 7'h41;
`ifdef HEX_MODE_EN
    if (sw_q_r[7]) begin
      hex1_s = glyph({2'b00, mag_s[5:4]});
      hex0_s = glyph(mag_s[3:0]);
      hex4_s = 7'h0B;
    end else begin
      hex4_s = hex4_s;
    end
`endif
    if (neg_s) hex3_s = 7'h3F;
    else       hex3_s = BLANK;
    led_s = {1'b0, (mag_s == 6'd0), neg_s, sw_q_r[6:0]};
  end

  // Input sampling stage and registered display stage.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sw_q_r <= 10'd0;
      led_r  <= 10'd0;
      hex0_r <= BLANK;
      hex1_r <= BLANK;
      hex2_r <= BLANK;
      hex3_r <= BLANK;
      hex4_r <= BLANK;
      hex5_r <= BLANK;
    end else begin
      sw_q_r <= board.SW;
      led_r  <= led_s;
      hex0_r <= hex0_s;
      hex1_r <= hex1_s;
      hex2_r <= BLANK;
      hex3_r <= hex3_s;
      hex4_r <= hex4_s;
      hex5_r <= BLANK;
    end
  end

  // Polarity applied after the registers so the reset value is inverted too.
  assign board.LED  = led_r;
  assign board.HEX0 = SEG_ACTIVE_LOW ? hex0_r : ~hex0_r;
  assign board.HEX1 = SEG_ACTIVE_LOW ? hex1_r : ~hex1_r;
  assign board.HEX2 = SEG_ACTIVE_LOW ? hex2_r : ~hex2_r;
  assign board.HEX3 = SEG_ACTIVE_LOW ? hex3_r : ~hex3_r;
  assign board.HEX4 = SEG_ACTIVE_LOW ? hex4_r : ~hex4_r;
  assign board.HEX5 = SEG_ACTIVE_LOW ? hex5_r : ~hex5_r;

endmodule

// File: tb/tb_project3a_top.sv
// Directed scoreboard bench for project3a_top; define HEX_MODE_EN to cover the hex display option.
module tb_project3a_top;

  localparam bit SEG_ACTIVE_LOW = 1'b1;
  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  logic [51:0] sb_q [$];

  project3a_top_if bus ();

  project3a_top #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .board    (bus)
  );

  always #10 clk = ~clk;

  function automatic logic [6:0] pol(input logic [6:0] g);
    return SEG_ACTIVE_LOW ? g : ~g;
  endfunction

  function automatic logic [51:0] blank_exp();
    return {10'd0, pol(7'h7F), pol(7'h7F), pol(7'h7F), pol(7'h7F), pol(7'h7F), pol(7'h7F)};
  endfunction

  // Reference: {LED, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}
  function automatic logic [51:0] model(input logic [9:0] sw);
    int v, mag;
    bit neg;
    logic [6:0] h0, h1, h3, h4;
    logic [9:0] led;
    if (sw[6]) v = int'($signed(sw[5:0]));
    else       v = int'(sw[5:0]);
    neg = (v < 0);
    mag = neg ? -v : v;
    h0 = GLYPH[mag % 10];
    h1 = ((mag / 10) != 0) ? GLYPH[mag / 10] : 7'h7F;
    h3 = neg ? 7'h3F : 7'h7F;
    h4 = sw[6] ? 7'h12 : 7'h41;
`ifdef HEX_MODE_EN
    if (sw[7]) begin
      h1 = GLYPH[mag / 16];
      h0 = GLYPH[mag % 16];
      h4 = 7'h0B;
    end
`endif
    led = {1'b0, (mag == 0), neg, sw[6:0]};
    return {led, pol(7'h7F), pol(h4), pol(h3), pol(7'h7F), pol(h1), pol(h0)};
  endfunction

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_out();
    logic [51:0] e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL sb_empty observed=0 expected=1");
    end else begin
      e = sb_q.pop_front();
      chk("LED",  bus.LED,          e[51:42]);
      chk("HEX5", {3'b0, bus.HEX5}, {3'b0, e[41:35]});
      chk("HEX4", {3'b0, bus.HEX4}, {3'b0, e[34:28]});
      chk("HEX3", {3'b0, bus.HEX3}, {3'b0, e[27:21]});
      chk("HEX2", {3'b0, bus.HEX2}, {3'b0, e[20:14]});
      chk("HEX1", {3'b0, bus.HEX1}, {3'b0, e[13:7]});
      chk("HEX0", {3'b0, bus.HEX0}, {3'b0, e[6:0]});
    end
  endtask

  task automatic drive(input logic [9:0] sw);
    @(negedge clk);
    bus.SW = sw;
    sb_q.push_back(model(sw));
    repeat (2) @(posedge clk);
    #1;
    compare_out();
  endtask

  initial begin
    reset  = 1'b1;
    bus.SW = 10'd0;
    repeat (2) @(posedge clk);
    #1;
    sb_q.push_back(blank_exp());
    compare_out();
    @(negedge clk);
    reset = 1'b0;

    drive(10'b0000011001);
    chk("t2_hex1", {3'b0, bus.HEX1}, {3'b0, pol(7'h24)});
    chk("t2_hex0", {3'b0, bus.HEX0}, {3'b0, pol(7'h12)});
    chk("t2_led",  bus.LED, 10'h019);
    drive(10'b0001011001);
    chk("t3_hex4", {3'b0, bus.HEX4}, {3'b0, pol(7'h12)});
    drive(10'b0000001110);
    drive(10'b0001010100);
    drive(10'b0001100000);
    chk("m32_hex3", {3'b0, bus.HEX3}, {3'b0, pol(7'h3F)});
    chk("m32_led",  bus.LED, 10'h0E0);
    drive(10'b0000000000);
    chk("zero_led8", {9'd0, bus.LED[8]}, 10'd1);
    drive(10'b0001111111);
    drive(10'b0001011111);
    drive(10'b0000111111);
    drive(10'b0000100000);
    drive(10'b1101110110);
    drive(10'b0010111111);
    drive(10'b0011111011);
    for (int i = 0; i < 6; i++) drive(10'($urandom_range(0, 1023)));

    @(negedge clk);
    reset  = 1'b1;
    bus.SW = 10'h03A;
    @(posedge clk);
    #1;
    sb_q.push_back(blank_exp());
    compare_out();
    @(negedge clk);
    bus.SW = 10'h045;
    @(posedge clk);
    #1;
    sb_q.push_back(blank_exp());
    compare_out();
    @(negedge clk);
    reset = 1'b0;
    sb_q.push_back(model(10'h045));
    repeat (2) @(posedge clk);
    #1;
    compare_out();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
